// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: datapath width, PC-select
// encodings, the bubble instruction and the fetch-wait FSM states.
package riscv_pkg;

    localparam int XLEN = 32;

    // Next-PC select driven by the branch controller in EX
    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // IMEM wait tracking
    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_t;

    // JALR clears bit 0 of the computed target; branch/JAL targets are not touched
    function automatic logic [XLEN-1:0] jalr_target(input logic [XLEN-1:0] alu_result);
        return {alu_result[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load. A load with no
// instruction available from IMEM inserts a bubble, same as a flush.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            ready,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] instrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            validD
);

    // Register update with flush > stall > load priority
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst || flush || (!stall && !ready)) begin
            instrD   <= BUBBLE;
            PCD      <= '0;
            PCPlus4D <= '0;
            validD   <= 1'b0;
        end else if (!stall) begin
            instrD   <= instr;
            PCD      <= pc;
            PCPlus4D <= pc_plus4;
            validD   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC select, IMEM wait FSM and the IF/ID
// register. A taken redirect from EX overrides every stall and flushes
// the wrong-path instruction sitting in IF/ID.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic [1:0]      PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] instrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            validD,
    output logic            flushE
);

    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] pc_plus4f;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] pc_next;
    logic            redirect;
    fetch_state_t    state;
    fetch_state_t    state_next;

    assign pc_plus4f = pcf + 32'd4;
    assign imem_addr = pcf;

    // Redirect decode and target select; reserved encoding 11 behaves as PC+4
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        redirect    = 1'b0;
        redirect_pc = pc_plus4f;
        case (PCSrcE)
            PCSRC_TARGET: begin
                redirect    = 1'b1;
                redirect_pc = PCTargetE;
            end
            PCSRC_JALR: begin
                redirect    = 1'b1;
                redirect_pc = jalr_target(ALUResultE);
            end
            default: ;
        endcase
    end

    assign flushE = redirect;

    // Next PC with redirect > stallF > IMEM wait > advance priority
    always_comb begin
        pc_next = pcf;
        if (redirect)
            pc_next = redirect_pc;
        else if (!stallF && imem_ready)
            pc_next = pc_plus4f;
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst)
            pcf <= RESET_PC;
        else
            pcf <= pc_next;
    end

    // FSM state register; reset also discards any outstanding IMEM wait
    always_ff @(posedge clk) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_next;
    end

    // FSM next state: a redirect aborts a wait and restarts at the target
    always_comb begin
        state_next = state;
        case (state)
            FETCH: if (!imem_ready && !redirect) state_next = WAIT;
            WAIT:  if (imem_ready || redirect)   state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // FSM outputs: the request stays up in both states, address held by PCF
    always_comb begin
        imem_req = 1'b0;
        case (state)
            FETCH, WAIT: imem_req = !rst;
            default:     imem_req = 1'b0;
        endcase
    end

    if_id_reg #(
        .BUBBLE (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .stall    (stallD),
        .ready    (imem_ready),
        .instr    (imem_rdata),
        .pc       (pcf),
        .pc_plus4 (pc_plus4f),
        .instrD   (instrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .validD   (validD)
    );

endmodule
